// File: rtl/fp_mac_feeder.sv
// fp_mac_feeder: sequences operand pairs into an external FP MAC and captures the dot-product result
// Ports: clk/reset (async active-low); start+len launch a job, busy while not idle;
// op_valid/op_ready/op_a/op_b accept operand pairs; mac_clr/mac_a/mac_b drive the MAC,
// mac_out is its accumulator; res_valid/res_ready/res_data return the captured result.
module fp_mac_feeder #(
  parameter int MAC_LAT = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             op_valid,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic             op_ready,
  output logic             mac_clr,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  input  logic [31:0]      mac_out,
  output logic             res_valid,
  output logic [31:0]      res_data,
  input  logic             res_ready
);
  localparam int DW = $clog2(MAC_LAT + 2);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [LEN_W-1:0] rem;
  logic [DW-1:0] drn;
  logic xfer, last;
  assign xfer = op_valid && op_ready;
  assign last = xfer && rem == LEN_W'(1);
  always_comb begin
    busy = state != IDLE;
    op_ready = state == FEED;
    mac_clr = state == CLEAR;
    res_valid = state == DONE;
    state_nx = state == IDLE  ? (start ? (len != '0 ? CLEAR : DONE) : IDLE)
             : state == CLEAR ? FEED
             : state == FEED  ? (last ? DRAIN : FEED)
             : state == DRAIN ? (drn == '0 ? DONE : DRAIN)
             : (res_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // mac_a/mac_b are zero on every edge without a transfer, covering CLEAR, bubbles and DRAIN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rem <= '0;
      drn <= '0;
      mac_a <= '0;
      mac_b <= '0;
      res_data <= '0;
    end else begin
      mac_a <= xfer ? op_a : '0;
      mac_b <= xfer ? op_b : '0;
      if (state == IDLE && start) rem <= len;
      else if (xfer) rem <= rem - LEN_W'(1);
      if (last) drn <= DW'(MAC_LAT);
      else if (state == DRAIN && drn != '0) drn <= drn - DW'(1);
      if (state == IDLE && start && len == '0) res_data <= '0;
      else if (state == DRAIN && drn == '0) res_data <= mac_out;
    end
endmodule

// File: tb/tb_fp_mac_feeder.sv
// tb_fp_mac_feeder: directed self-checking bench for fp_mac_feeder with a behavioural FP MAC
module tb_fp_mac_feeder;
  localparam int MAC_LAT = 4;
  localparam int PD = MAC_LAT - 1;
  logic clk = 0, reset = 0, start = 0, op_valid = 0, res_ready = 1;
  logic [7:0] len = 0;
  logic [31:0] op_a = 0, op_b = 0;
  logic busy, op_ready, mac_clr, res_valid;
  logic [31:0] mac_a, mac_b, mac_out, res_data;
  int checks = 0, errors = 0;
  int cyc = 0, xfer_cnt = 0, last_xfer = 0, clr_cnt = 0, rdy_cnt = 0;
  logic [31:0] exp_q[$];
  real p[PD];
  real acc = 0.0;
  always #5 clk = ~clk;
  fp_mac_feeder #(.MAC_LAT(MAC_LAT), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
  );
  function automatic real f2r(input logic [31:0] b);
    if (b[30:0] == 31'd0) return 0.0;
    return $bitstoreal({b[31], 11'(b[30:23]) - 11'd127 + 11'd1023, b[22:0], 29'd0});
  endfunction
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd1023 + 11'd127), d[51:29]};
  endfunction
  // MAC samples mac_a/mac_b at an edge; the product reaches mac_out MAC_LAT edges later
  assign mac_out = r2f(acc);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (op_valid && op_ready) begin
      xfer_cnt <= xfer_cnt + 1;
      last_xfer <= cyc + 1;
    end
    if (mac_clr) clr_cnt <= clr_cnt + 1;
    if (op_ready) rdy_cnt <= rdy_cnt + 1;
    if (mac_clr) begin
      acc <= 0.0;
      for (int i = 0; i < PD; i++) p[i] <= 0.0;
    end else begin
      p[0] <= f2r(mac_a) * f2r(mac_b);
      for (int i = 1; i < PD; i++) p[i] <= p[i-1];
      acc <= acc + p[PD-1];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [7:0] n, input logic [31:0] e);
    start = 1;
    len = n;
    exp_q.push_back(e);
    tick();
    start = 0;
  endtask
  task automatic feed(input logic [31:0] a, input logic [31:0] b, input int gap);
    int n = xfer_cnt;
    int t = 0;
    op_valid = 1;
    op_a = a;
    op_b = b;
    do begin
      tick();
      t++;
    end while (xfer_cnt == n && t < 20);
    op_valid = 0;
    chk("xfer", 32'(xfer_cnt - n), 32'd1);
    chk("mac_a_copy", mac_a, a);
    chk("mac_b_copy", mac_b, b);
    for (int g = 0; g < gap; g++) begin
      tick();
      chk("gap_mac_a", mac_a, 32'd0);
      chk("gap_mac_b", mac_b, 32'd0);
    end
  endtask
  task automatic wait_res(input string tag, input int lat);
    int t = 0;
    logic [31:0] e;
    while (!res_valid && t < 50) begin
      tick();
      t++;
    end
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hdead_beef;
    chk({tag, "_data"}, res_data, e);
    if (lat >= 0) chk({tag, "_lat"}, 32'(cyc - last_xfer), 32'(lat));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_op_ready"}, 32'(op_ready), 32'd0);
    chk({tag, "_mac_clr"}, 32'(mac_clr), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_mac_a"}, mac_a, 32'd0);
    chk({tag, "_mac_b"}, mac_b, 32'd0);
    chk({tag, "_res_data"}, res_data, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int s, c0, r0;
    logic [31:0] hold;
    tick();
    tick();
    chk_zero("reset");
    reset = 1;
    tick();
    s = cyc;
    c0 = clr_cnt;
    go(2, 32'h4160_0000);
    chk("first_start_busy", 32'(busy), 32'd1);
    chk("clear_mac_clr", 32'(mac_clr), 32'd1);
    chk("clear_mac_a", mac_a, 32'd0);
    feed(32'h3F80_0000, 32'h4000_0000, 0);
    chk("feed_mac_clr_low", 32'(mac_clr), 32'd0);
    feed(32'h4040_0000, 32'h4080_0000, 0);
    wait_res("basic", MAC_LAT + 1);
    chk("basic_total", 32'(cyc - s - 1), 32'(1 + 2 + MAC_LAT + 1));
    chk("basic_clr_cycles", 32'(clr_cnt - c0), 32'd1);
    tick();
    chk("basic_idle", 32'(busy), 32'd0);
    c0 = clr_cnt;
    r0 = rdy_cnt;
    go(0, 32'h0000_0000);
    chk("zero_immediate", 32'(res_valid), 32'd1);
    wait_res("zero", -1);
    chk("zero_no_clr", 32'(clr_cnt - c0), 32'd0);
    chk("zero_no_ready", 32'(rdy_cnt - r0), 32'd0);
    tick();
    chk("zero_idle", 32'(res_valid), 32'd0);
    go(3, 32'h4040_0000);
    tick();
    feed(32'h3F80_0000, 32'h3F80_0000, 2);
    feed(32'h3F80_0000, 32'h3F80_0000, 2);
    feed(32'h3F80_0000, 32'h3F80_0000, 0);
    wait_res("bubble", MAC_LAT + 1);
    tick();
    res_ready = 0;
    go(1, 32'h4040_0000);
    feed(32'h3FC0_0000, 32'h4000_0000, 0);
    wait_res("bp", MAC_LAT + 1);
    hold = res_data;
    r0 = rdy_cnt;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2) == 0;
      len = 8'd3;
      tick();
      chk("bp_valid_held", 32'(res_valid), 32'd1);
      chk("bp_data_held", res_data, hold);
    end
    start = 0;
    chk("bp_start_ignored", 32'(rdy_cnt - r0), 32'd0);
    res_ready = 1;
    tick();
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_valid", 32'(res_valid), 32'd0);
    go(4, 32'h0);
    feed(32'h4040_0000, 32'h4040_0000, 0);
    void'(exp_q.pop_back());
    #2 reset = 0;
    #1 chk_zero("midrst");
    tick();
    reset = 1;
    go(1, 32'h4080_0000);
    chk("post_rst_busy", 32'(busy), 32'd1);
    tick();
    feed(32'h4000_0000, 32'h4000_0000, 0);
    wait_res("post_rst", MAC_LAT + 1);
    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_mac_feeder.md
FP_MAC_FEEDER -- requirements
Module: fp_mac_feeder

Interface
REQ-001 SHALL have parameter MAC_LAT, default 4: edges from the MAC sampling a pair on mac_a/mac_b until its contribution appears on mac_out.
REQ-002 SHALL have parameter LEN_W, default 8: job length counter width.
REQ-003 SHALL have ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  job start pulse; sampled only in IDLE.
- len  input  LEN_W  number of operand pairs in the job; sampled with start.
- busy  output  1  high in every state except IDLE.
- op_valid  input  1  operand pair valid.
- op_a  input  32  IEEE-754 single multiplicand.
- op_b  input  32  IEEE-754 single multiplier.
- op_ready  output  1  feeder accepts a pair this cycle.
- mac_clr  output  1  active-high synchronous clear to the MAC.
- mac_a  output  32  registered multiplicand to the MAC.
- mac_b  output  32  registered multiplier to the MAC.
- mac_out  input  32  MAC accumulator value.
- res_valid  output  1  result valid.
- res_data  output  32  captured dot-product result.
- res_ready  input  1  result consumer ready.

Function
REQ-004 SHALL implement states IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-005 IDLE, start=1, len!=0: latch len into remaining counter; go to CLEAR.
REQ-006 IDLE, start=1, len=0: set res_data=32'h0000_0000; go to DONE. The MAC is not touched.
REQ-007 start SHALL be ignored in every state other than IDLE.
REQ-008 CLEAR SHALL last exactly one cycle, with mac_clr=1 and mac_a=mac_b=0. Then go to FEED.
REQ-009 mac_clr SHALL be 0 in all states except CLEAR.
REQ-010 op_ready SHALL be 1 only in FEED, combinationally from state.
REQ-011 Handshake: a pair transfers on an edge where op_valid=1 and op_ready=1. op_a/op_b are registered onto mac_a/mac_b at that edge. Remaining count decrements by 1.
REQ-012 Any FEED cycle without a transfer (bubble) SHALL register mac_a=mac_b=32'h0000_0000.
REQ-013 The transfer that takes the remaining count to 0 SHALL move to DRAIN and load the drain counter with MAC_LAT.
REQ-014 In DRAIN, mac_a=mac_b=0 each cycle; the drain counter decrements each cycle.
REQ-015 The drain counter reaching 0 SHALL capture mac_out into res_data and move to DONE.
REQ-016 res_data SHALL be captured exactly MAC_LAT+1 edges after the last-transfer edge. res_valid rises on that same edge.
REQ-017 DONE: res_valid=1 and res_data SHALL be held stable until res_ready=1. On that edge go to IDLE and drop res_valid.
REQ-018 op_valid outside FEED SHALL have no effect; no pair is consumed.
REQ-019 There SHALL be no arithmetic on operands. mac_a/mac_b carry bit-exact copies of op_a/op_b.
REQ-020 Throughput: one pair per cycle when op_valid is held high. A job of len=N with no bubbles completes in 1+N+MAC_LAT+1 cycles after the start edge.

Reset
REQ-021 While reset=0, asynchronously: state=IDLE and counters=0; busy, op_ready, mac_clr and res_valid =0; mac_a, mac_b and res_data =32'h0.
REQ-022 Reset asserted mid-job SHALL abort the job with no result produced. The next job's CLEAR cycle re-clears the MAC.
REQ-023 After reset deasserts, the first start SHALL be honoured on the next rising edge.

Verification
REQ-024 Basic job: len=2, pairs (0x3F800000,0x40000000) and (0x40400000,0x40800000) back-to-back, res_ready=1. Required: res_data=0x41600000 (14.0) with res_valid exactly MAC_LAT+1 edges after the second transfer; mac_clr high for exactly one cycle.
REQ-025 Zero length: start with len=0. Required: res_valid=1 with res_data=0x00000000 one edge after start; mac_clr never asserted; op_ready never asserted.
REQ-026 Bubbles: len=3, each of 1.0×1.0 with op_valid low for 2 cycles between pairs. Required: mac_a/mac_b=0 during every gap; res_data=0x40400000 (3.0).
REQ-027 Backpressure: hold res_ready=0 for 5 cycles in DONE. Required: res_valid and res_data stable; start pulses in that window are ignored; IDLE is entered on the res_ready edge.
REQ-028 Mid-job reset: drop reset after 1 of 4 pairs. Required: all outputs go to 0 immediately. A following len=1 job of (2.0,2.0) returns 0x40800000 (4.0), with no stale accumulation.
